seg7_display_ctrl: RTL

SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/seg7_display_ctrl_if.sv | 20 ++
 rtl/seg7_hex_decoder.sv | 43 ++++
 rtl/seg7_display_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the seven-segment display controller:
//               data-path width, poll FSM state encoding and digit count.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int SEG7_DIGITS = 8;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ADDR  = 2'd1,
        LATCH = 2'd2
    } seg7_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/seg7_display_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_mem_if
// Description : Word-read port between the display controller and the core's
//               data memory. The controller presents addr_o; the memory side
//               returns data_i combinationally.
//   master : controller side (drives addr_o, receives data_i)
//   slave  : memory side     (receives addr_o, drives data_i)
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_mem_if;

    logic [riscv_pkg::XLEN-1:0] addr_o;
    logic [riscv_pkg::XLEN-1:0] data_i;

    modport master (output addr_o, input  data_i);
    modport slave  (input  addr_o, output data_i);

endinterface : seg7_mem_if
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational nibble-to-glyph decoder, active-low segments
//               ordered {g,f,e,d,c,b,a}. blank_i forces all segments off.
//   nibble_i : 4-bit value to display
//   blank_i  : 1 = extinguish the digit
//   seg_o    : active-low segment drive
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder (
    input  wire logic [3:0] nibble_i,
    input  wire logic       blank_i,
    output logic      [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        if (!blank_i) begin
            case (nibble_i)
                4'h0: seg_o = 7'b1000000;
                4'h1: seg_o = 7'b1111001;
                4'h2: seg_o = 7'b0100100;
                4'h3: seg_o = 7'b0110000;
                4'h4: seg_o = 7'b0011001;
                4'h5: seg_o = 7'b0010010;
                4'h6: seg_o = 7'b0000010;
                4'h7: seg_o = 7'b1111000;
                4'h8: seg_o = 7'b0000000;
                4'h9: seg_o = 7'b0010000;
                4'hA: seg_o = 7'b0001000;
                4'hB: seg_o = 7'b0000011;
                4'hC: seg_o = 7'b1000110;
                4'hD: seg_o = 7'b0100001;
                4'hE: seg_o = 7'b0000110;
                4'hF: seg_o = 7'b0001110;
                default: seg_o = 7'b1111111;
            endcase
        end
    end

endmodule : seg7_hex_decoder
`default_nettype wire

// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display_ctrl
// Description : Periodically polls one data-memory word and shows it in hex on
//               an 8-digit multiplexed, active-low seven-segment display.
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset (dominates en_i)
//   en_i      : polling enable
//   mem       : seg7_mem_if.master, word read port (addr_o / data_i)
//   value_o   : currently displayed word
//   update_o  : one-cycle pulse when the displayed word changes
//   anode_o   : digit select, active-low, one-hot-low
//   seg_o     : segments {g,f,e,d,c,b,a}, active-low
//   dp_o      : decimal point, always off (1)
// Build option: SEG7_BLANK_LEADING_ZERO_EN blanks digits above the most
//               significant nonzero nibble (digit 0 is never blanked).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_ctrl
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] DISP_ADDR    = 'h0,
    parameter int              POLL_CYCLES  = 100000,
    parameter int              DIGIT_CYCLES = 1000
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            en_i,
    seg7_mem_if.master           mem,
    output logic      [XLEN-1:0] value_o,
    output logic                 update_o,
    output logic           [7:0] anode_o,
    output logic           [6:0] seg_o,
    output logic                 dp_o
);

    localparam int              PW        = $clog2(POLL_CYCLES);
    localparam int              DW        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [DW-1:0]   DIG_LAST  = DW'(DIGIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Poll FSM
    // ------------------------------------------------------------------
    seg7_state_e     state_q, state_d;
    logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [XLEN-1:0] value_q;
    logic            update_q;
    logic            capture_w;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= WAIT;
            poll_cnt_q <= '0;
            value_q    <= '0;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            update_q   <= capture_w && (mem.data_i != value_q);
            if (capture_w) begin
                value_q <= mem.data_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        capture_w  = 1'b0;
        mem.addr_o = '0;
        case (state_q)
            WAIT: begin
                if (en_i) begin
                    if (poll_cnt_q == POLL_LAST) begin
                        poll_cnt_d = '0;
                        state_d    = ADDR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                end
            end
            // Once a poll has started it completes regardless of en_i.
            ADDR: begin
                mem.addr_o = DISP_ADDR;
                state_d    = LATCH;
            end
            LATCH: begin
                mem.addr_o = DISP_ADDR;
                capture_w  = 1'b1;
                state_d    = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit multiplexing
    // ------------------------------------------------------------------
    logic [DW-1:0] digit_cnt_q;
    logic [2:0]    digit_idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_cnt_q <= '0;
            digit_idx_q <= '0;
        end else if (digit_cnt_q == DIG_LAST) begin
            digit_cnt_q <= '0;
            digit_idx_q <= digit_idx_q + 3'd1;
        end else begin
            digit_cnt_q <= digit_cnt_q + 1'b1;
        end
    end

    logic [3:0] nibble_w;
    logic       blank_w;

    // The lit digit reads value_q directly, so a new capture shows at once.
    assign nibble_w = value_q[{digit_idx_q, 2'b00} +: 4];

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    logic [2:0] top_digit_w;

    // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 shows "0".
    always_comb begin
        top_digit_w = '0;
        for (int k = 1; k < SEG7_DIGITS; k++) begin
            if (value_q[4*k +: 4] != 4'h0) begin
                top_digit_w = 3'(k);
            end
        end
    end

    assign blank_w = (digit_idx_q > top_digit_w);
`else
    assign blank_w = 1'b0;
`endif

    seg7_hex_decoder u_hex_decoder (
        .nibble_i (nibble_w),
        .blank_i  (blank_w),
        .seg_o    (seg_o)
    );

    assign anode_o  = ~(8'b0000_0001 << digit_idx_q);
    assign value_o  = value_q;
    assign update_o = update_q;
    assign dp_o     = 1'b1;

endmodule : seg7_display_ctrl
`default_nettype wire
